// File: rtl/phy_link_ctrl.sv
// Link-level controller for the two-lane byte PHY: bring-up sequencing, threshold
// programming, and per-lane hysteresis back-pressure on the transmit FIFO pops.
module phy_link_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk_f,
    input  logic             reset,
    input  logic             init,
    input  logic [CNT_W-1:0] umbral_bajo_in,
    input  logic [CNT_W-1:0] umbral_alto_in,
    input  logic             phy_ready,
    input  logic             fifo_empty_0,
    input  logic             fifo_empty_1,
    input  logic [CNT_W-1:0] down_count_0,
    input  logic [CNT_W-1:0] down_count_1,
    input  logic             fifo_err,
    output logic             phy_enable,
    output logic             pop_0,
    output logic             pop_1,
    output logic             valid_data_in_0,
    output logic             valid_data_in_1,
    output logic [CNT_W-1:0] umbral_bajo_out,
    output logic [CNT_W-1:0] umbral_alto_out,
    output logic [4:0]       state,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out
);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t           state_q, state_d;
    logic             pause_0_q, pause_1_q;
    logic             pause_0_d, pause_1_d;
    logic [CNT_W-1:0] bajo_q, alto_q;
    logic             any_data;

    assign any_data = !fifo_empty_0 || !fifo_empty_1;

    // Next state: fifo_err outranks init; RESET always moves on to INIT, ERROR is sticky.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_ERROR:  state_d = S_ERROR;
            default: begin
                if (fifo_err) begin
                    state_d = S_ERROR;
                end else if (init) begin
                    state_d = S_INIT;
                end else begin
                    case (state_q)
                        S_INIT:   state_d = S_IDLE;
                        S_IDLE:   if (phy_ready && any_data) state_d = S_ACTIVE;
                        S_ACTIVE: if (!any_data || !phy_ready) state_d = S_IDLE;
                        default:  state_d = S_ERROR;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Thresholds track the inputs while in INIT; the last INIT cycle's values stick.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            bajo_q <= '0;
            alto_q <= '0;
        end else if (state_q == S_INIT) begin
            bajo_q <= umbral_bajo_in;
            alto_q <= umbral_alto_in;
        end
    end

    // Hysteresis: set at or above alto, clear at or below bajo, set wins if both hold.
    always_comb begin
        pause_0_d = pause_0_q;
        pause_1_d = pause_1_q;
        if (state_q != S_ACTIVE) begin
            pause_0_d = 1'b0;
            pause_1_d = 1'b0;
        end else begin
            if (down_count_0 >= alto_q)      pause_0_d = 1'b1;
            else if (down_count_0 <= bajo_q) pause_0_d = 1'b0;
            if (down_count_1 >= alto_q)      pause_1_d = 1'b1;
            else if (down_count_1 <= bajo_q) pause_1_d = 1'b0;
        end
    end

    // Lane handshake: pop_x is the FIFO read strobe this cycle; the byte appears
    // on data_in_x one cycle later, flagged by valid_data_in_x (pop_x delayed).
    assign pop_0 = (state_q == S_ACTIVE) && !fifo_empty_0 && !pause_0_q;
    assign pop_1 = (state_q == S_ACTIVE) && !fifo_empty_1 && !pause_1_q;

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            pause_0_q       <= 1'b0;
            pause_1_q       <= 1'b0;
            valid_data_in_0 <= 1'b0;
            valid_data_in_1 <= 1'b0;
        end else begin
            pause_0_q       <= pause_0_d;
            pause_1_q       <= pause_1_d;
            valid_data_in_0 <= pop_0;
            valid_data_in_1 <= pop_1;
        end
    end

    assign umbral_bajo_out = bajo_q;
    assign umbral_alto_out = alto_q;
    assign state           = state_q;
    assign phy_enable      = (state_q == S_INIT) || (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign idle_out        = (state_q == S_IDLE);
    assign active_out      = (state_q == S_ACTIVE);
    assign error_out       = (state_q == S_ERROR);

endmodule
